// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank: serial config chain with commit, registered pad outputs, synchronised inputs.
// Optional sticky rising-edge interrupt flags when GPIO_BANK_IRQ_EN is defined.
module gpio_bank #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           CK,
    input  logic           RST,
    input  logic           ccff_head,
    input  logic           ccff_en,
    input  logic           ccff_commit,
    output logic           ccff_tail,
    input  logic [NCH-1:0] A,
    output logic [NCH-1:0] Y,
    output logic [NCH-1:0] PAD_OUT,
    output logic [NCH-1:0] PAD_OE,
    input  logic [NCH-1:0] PAD_IN,
    input  logic [NCH-1:0] irq_clr,
    output logic [NCH-1:0] irq_flag,
    output logic           irq
);

    localparam int CW = 2 * NCH;

    logic [CW-1:0]  chain_q, chain_d;
    logic [NCH-1:0] dir_q, dir_d;
    logic [NCH-1:0] pol_q, pol_d;
    logic [NCH-1:0] pad_out_q, pad_out_d;
    logic [NCH-1:0] pad_oe_q, pad_oe_d;
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync_d [SYNC_STAGES];

    // Commit reads chain_q, so a simultaneous shift never leaks into the committed value.
    always_comb begin
        chain_d = chain_q;
        if (ccff_en) begin
            chain_d = {chain_q[CW-2:0], ccff_head};
        end
        dir_d = dir_q;
        pol_d = pol_q;
        if (ccff_commit) begin
            for (int i = 0; i < NCH; i++) begin
                dir_d[i] = chain_q[2*i];
                pol_d[i] = chain_q[2*i+1];
            end
        end
        pad_out_d = A ^ pol_q;
        pad_oe_d  = dir_q;
        sync_d[0] = PAD_IN;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            chain_q   <= '0;
            dir_q     <= '0;
            pol_q     <= '0;
            pad_out_q <= '0;
            pad_oe_q  <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            chain_q   <= chain_d;
            dir_q     <= dir_d;
            pol_q     <= pol_d;
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign ccff_tail = chain_q[CW-1];
    assign PAD_OUT   = pad_out_q;
    assign PAD_OE    = pad_oe_q;
    assign Y         = sync_q[SYNC_STAGES-1] ^ pol_q;

`ifdef GPIO_BANK_IRQ_EN
    logic [NCH-1:0] yp_q, yp_d;
    logic [NCH-1:0] flag_q, flag_d;
    logic [NCH-1:0] edge_det;
    logic           cmt_d_q, cmt_d_d;

    // cmt_d masks the cycle where a polarity change alone would look like an edge.
    always_comb begin
        yp_d     = Y;
        cmt_d_d  = ccff_commit;
        edge_det = Y & ~yp_q & ~dir_q & {NCH{~cmt_d_q}};
        flag_d   = (flag_q & ~irq_clr) | edge_det;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            yp_q    <= '0;
            cmt_d_q <= 1'b0;
            flag_q  <= '0;
        end else begin
            yp_q    <= yp_d;
            cmt_d_q <= cmt_d_d;
            flag_q  <= flag_d;
        end
    end

    assign irq_flag = flag_q;
    assign irq      = |flag_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = ^irq_clr;
    assign irq_flag       = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - directed self-checking bench for gpio_bank (NCH=8, SYNC_STAGES=2).
// Interrupt expectations follow GPIO_BANK_IRQ_EN.
module tb_gpio_bank;

    localparam int NCH = 8;
`ifdef GPIO_BANK_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic           CK          = 1'b0;
    logic           RST         = 1'b0;
    logic           ccff_head   = 1'b0;
    logic           ccff_en     = 1'b0;
    logic           ccff_commit = 1'b0;
    logic           ccff_tail;
    logic [NCH-1:0] A           = '0;
    logic [NCH-1:0] Y;
    logic [NCH-1:0] PAD_OUT;
    logic [NCH-1:0] PAD_OE;
    logic [NCH-1:0] PAD_IN      = '0;
    logic [NCH-1:0] irq_clr     = '0;
    logic [NCH-1:0] irq_flag;
    logic           irq;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] p1, p2, cfg_word, exp_tail, tail_en, tail_dis;

    gpio_bank #(.NCH(NCH), .SYNC_STAGES(2)) dut (
        .CK          (CK),
        .RST         (RST),
        .ccff_head   (ccff_head),
        .ccff_en     (ccff_en),
        .ccff_commit (ccff_commit),
        .ccff_tail   (ccff_tail),
        .A           (A),
        .Y           (Y),
        .PAD_OUT     (PAD_OUT),
        .PAD_OE      (PAD_OE),
        .PAD_IN      (PAD_IN),
        .irq_clr     (irq_clr),
        .irq_flag    (irq_flag),
        .irq         (irq)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CK);
    endtask

    task automatic shift_bit(input logic b);
        ccff_en   = 1'b1;
        ccff_head = b;
        tick();
        ccff_en   = 1'b0;
    endtask

    task automatic commit_pulse();
        ccff_commit = 1'b1;
        tick();
        ccff_commit = 1'b0;
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int k = 15; k >= 0; k--) shift_bit(w[k]);
    endtask

    task automatic load_cfg(input logic [NCH-1:0] dir, input logic [NCH-1:0] pol);
        for (int k = 2*NCH-1; k >= 0; k--) begin
            if (k % 2 == 1) shift_bit(pol[k/2]);
            else            shift_bit(dir[k/2]);
        end
        commit_pulse();
    endtask

    initial begin
        // Reset state, with live-looking inputs applied
        #1 RST = 1'b1;
        A      = 8'hFF;
        PAD_IN = 8'hFF;
        #12;
        check("rst_pad_oe", PAD_OE, 8'h00);
        check("rst_pad_out", PAD_OUT, 8'h00);
        check("rst_y", Y, 8'h00);
        check("rst_tail", ccff_tail, 1'b0);
        check("rst_irq_flag", irq_flag, 8'h00);
        check("rst_irq", irq, 1'b0);
        tick();
        RST    = 1'b0;
        A      = 8'h00;
        PAD_IN = 8'h00;

        // 0xAAAA MSB-first: all inputs, all inverted
        shift_word(16'hAAAA);
        check("tail_first_bit", ccff_tail, 1'b1);
        commit_pulse();
        check("aaaa_y_inverted", Y, 8'hFF);
        check("aaaa_pad_oe_commit_edge", PAD_OE, 8'h00);
        tick();
        check("aaaa_pad_out", PAD_OUT, 8'hFF);
        check("aaaa_pad_oe", PAD_OE, 8'h00);
        tick();
        tick();
        check("pol_flip_no_irq", irq_flag, 8'h00);

        // Gated shifting: tail equals head delayed by 16 enabled cycles
        p1 = 16'hC3A5;
        p2 = 16'h5E19;
        for (int j = 0; j < 16; j++) begin
            shift_bit(p1[15-j]);
            ccff_head = ~p1[15-j];
            tick();
        end
        for (int j = 0; j < 16; j++) begin
            shift_bit(p2[15-j]);
            tail_en[15-j] = ccff_tail;
            ccff_head = ~p2[15-j];
            tick();
            tail_dis[15-j] = ccff_tail;
        end
        exp_tail = {p1[14:0], p2[15]};
        check("tail_delay_enabled", tail_en, exp_tail);
        check("tail_hold_disabled", tail_dis, exp_tail);

        // Output path: dir=0x0F, pol=0
        load_cfg(8'h0F, 8'h00);
        tick();
        A = 8'h5A;
        check("pad_out_before_edge", PAD_OUT, 8'h00);
        tick();
        check("pad_out_5a", PAD_OUT, 8'h5A);
        check("pad_oe_0f", PAD_OE, 8'h0F);
        PAD_IN = 8'h0A;
        tick();
        tick();
        check("y_readback_outputs", Y, 8'h0A);
        tick();
        check("no_irq_on_outputs", irq_flag, 8'h00);
        PAD_IN = 8'h00;
        repeat (3) tick();

        // Channel 3 as input: sync latency and sticky flag
        load_cfg(8'hF0, 8'h00);
        PAD_IN = 8'h08;
        tick();
        check("y3_after_1", Y, 8'h00);
        tick();
        check("y3_after_2", Y, 8'h08);
        check("flag3_not_yet", irq_flag, 8'h00);
        tick();
        check("flag3_set", irq_flag, IRQ_ON ? 8'h08 : 8'h00);
        check("irq_set", irq, IRQ_ON);
        PAD_IN = 8'h00;
        repeat (3) tick();
        PAD_IN = 8'h08;
        tick();
        tick();
        irq_clr = 8'h08;
        tick();
        irq_clr = 8'h00;
        check("set_wins_over_clr", irq_flag, IRQ_ON ? 8'h08 : 8'h00);
        irq_clr = 8'h08;
        tick();
        irq_clr = 8'h00;
        check("clr_flag", irq_flag, 8'h00);
        check("clr_irq", irq, 1'b0);
        PAD_IN = 8'hF8;
        repeat (3) tick();
        check("y_f8", Y, 8'hF8);
        check("no_flag_output_chans", irq_flag, 8'h00);

        // Polarity flip on idle inputs
        load_cfg(8'hF0, 8'h0F);
        check("pol_flip_y", Y, 8'hF7);
        tick();
        tick();
        check("pol_flip_no_irq2", irq_flag, 8'h00);

        // Commit coinciding with a shift takes the pre-shift chain
        cfg_word = 16'hAAAA;
        shift_word(cfg_word);
        ccff_en     = 1'b1;
        ccff_head   = 1'b1;
        ccff_commit = 1'b1;
        tick();
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
        check("commit_pre_shift_y", Y, 8'h07);
        tick();
        check("commit_pre_shift_oe", PAD_OE, 8'h00);
        check("commit_pre_shift_out", PAD_OUT, 8'hA5);
        check("commit_pre_shift_irq", irq_flag, 8'h00);

        // Reset in the middle of a shift
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
        repeat (7) tick();
        #2 RST = 1'b1;
        #1;
        check("midrst_pad_oe", PAD_OE, 8'h00);
        check("midrst_pad_out", PAD_OUT, 8'h00);
        check("midrst_y", Y, 8'h00);
        check("midrst_tail", ccff_tail, 1'b0);
        check("midrst_irq_flag", irq_flag, 8'h00);
        check("midrst_irq", irq, 1'b0);
        ccff_en = 1'b0;
        tick();
        RST = 1'b0;
        commit_pulse();
        check("post_rst_y_sync", Y, 8'h00);
        tick();
        check("post_rst_pad_oe", PAD_OE, 8'h00);
        check("post_rst_pad_out", PAD_OUT, 8'h5A);
        check("post_rst_y", Y, 8'hF8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised bank of NCH general-purpose I/O channels sitting between the FPGA core I/O tiles and the external pad ring. Per-channel direction and polarity come from a serially loaded configuration chain with a shadow/commit stage, so shifting never disturbs live pads. Outputs are registered toward the pads. Inputs pass through a multi-stage synchroniser before reaching the core, with optional sticky rising-edge interrupt flags.

## Interface
- NCH, 8, number of channels (1..32)
- SYNC_STAGES, 2, input synchroniser depth (2..4)

- CK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- ccff_head  in  1  serial configuration data in
- ccff_en  in  1  shift enable for configuration chain
- ccff_commit  in  1  copy chain into active configuration (single-cycle pulse)
- ccff_tail  out  1  serial configuration data out, = chain[2*NCH-1]
- A  in  NCH  core-side output data
- Y  out  NCH  core-side synchronised input data
- PAD_OUT  out  NCH  pad output data
- PAD_OE  out  NCH  pad output enable, 1 = drive
- PAD_IN  in  NCH  pad input data, asynchronous
- irq_clr  in  NCH  per-channel interrupt-flag clear
- irq_flag  out  NCH  sticky rising-edge flags
- irq  out  1  OR of irq_flag

## Operation
- Configuration chain: 2*NCH-bit shift register `chain`. When ccff_en=1: chain <= {chain[2*NCH-2:0], ccff_head}. When ccff_en=0: chain holds.
- Active configuration: dir[i] and pol[i], loaded on ccff_commit from chain[2i] and chain[2i+1]. dir=1 means output, pol=1 means invert.
- If ccff_en and ccff_commit are both asserted in the same cycle, the commit captures chain as it was before that edge's shift.
- Output path: PAD_OUT[i] <= A[i] ^ pol[i]. PAD_OE[i] <= dir[i]. Both registered.
- Input path: PAD_IN[i] passes through a SYNC_STAGES-deep flop chain. Y[i] = sync_last[i] ^ pol[i]. Y is valid regardless of dir, so readback of a driven pad works.
- Edge detect, only with the macro below: yp <= Y each cycle. edge[i] = Y[i] & ~yp[i] & ~dir[i] & ~cmt_d, where cmt_d is ccff_commit delayed by 1 cycle. The cmt_d term suppresses spurious edges caused by a polarity change.
- Flag update: irq_flag[i] <= (irq_flag[i] & ~irq_clr[i]) | edge[i]. When set and clear happen in the same cycle, set wins.
- Reset values: chain=0, dir=0 (all channels are inputs), pol=0, PAD_OE=0, PAD_OUT=0, sync flops=0, Y=0, yp=0, cmt_d=0, irq_flag=0, irq=0, ccff_tail=0.
- Asserting RST mid-shift or mid-commit discards all configuration. The bank returns to all-input state asynchronously.

## Timing
- A to PAD_OUT: 1 cycle.
- ccff_commit at edge t: PAD_OE and PAD_OUT reflect the new dir/pol at edge t+1. Y reflects the new pol immediately after edge t.
- PAD_IN to Y: SYNC_STAGES cycles, plus up to 1 cycle of sampling uncertainty.
- Y rising after edge t: irq_flag and irq high after edge t+1.
- ccff_head bit to ccff_tail: exactly 2*NCH enabled shift cycles. Cycles with ccff_en=0 do not count.
- Full bank load: 2*NCH shift cycles followed by one commit cycle. The first bit shifted in lands in pol[NCH-1].

## Configuration
- GPIO_BANK_IRQ_EN defined: yp, cmt_d, edge logic and irq_flag registers are compiled in and behave as described above.
- GPIO_BANK_IRQ_EN undefined: irq_flag and irq are tied to 0, irq_clr is ignored, and no edge-detect registers exist. All other behaviour is unchanged.

## Test plan
- Reset, then NCH=8, shift 16 bits 0xAAAA MSB-first, then commit → dir[i]=0 and pol[i]=1 for all i. Y=0xFF while PAD_IN=0x00. PAD_OE=0x00.
- Shift a pattern with ccff_en toggling every other cycle → ccff_tail matches ccff_head delayed by 16 enabled cycles. Chain does not move on disabled cycles.
- Config dir=0x0F, pol=0; drive A=0x5A → PAD_OE=0x0F and PAD_OUT=0x5A one cycle after A changes.
- Input channel 3 with PAD_IN[3] 0→1 (GPIO_BANK_IRQ_EN defined) → Y[3]=1 after 2 cycles and irq_flag[3]=1 the following cycle. Pulse irq_clr[3] on the same cycle as a new edge → flag stays 1. Clear alone → flag=0 and irq=0.
- Commit that flips pol on idle input channels → Y toggles but irq_flag stays 0x00. Commit issued in the same cycle as a shift → the pre-shift value is committed.
- Assert RST mid-shift after 7 bits → all outputs return to reset values immediately. A subsequent commit without shifting yields dir=0 and pol=0.
